// File: rtl/wb_regfile_hilo.sv
// ---------------------------------------------------------------------------
// wb_regfile_hilo
//
// Consumer end of the writeback-to-register-file bus. Holds the general
// purpose register file (register 0 hardwired to zero) and the HI/LO pair
// used by multiply/divide and move-to-HI/LO instructions.
//
// Ports:
//   clk           clock
//   rst           synchronous, active-high reset; clears GPRs, HI and LO
//   wb_to_rf_bus  writeback bus, MSB first:
//                   [104:103] mt_flag   (2'b10 MTHI, 2'b01 MTLO)
//                   [102]     div_flag
//                   [101:38]  div_result ([101:70] HI, [69:38] LO)
//                   [37]      rf_we
//                   [36:32]   rf_waddr
//                   [31:0]    rf_wdata
//   raddr1/rdata1 GPR read port 1 (combinational, write-first forwarding)
//   raddr2/rdata2 GPR read port 2 (combinational, write-first forwarding)
//   hi_rdata      HI value
//   lo_rdata      LO value
//
// Build option:
//   HILO_BYPASS_EN  when defined, hi_rdata/lo_rdata forward the value being
//                   written this cycle; otherwise they show the registers
//                   and a new value appears one cycle after the write.
// ---------------------------------------------------------------------------
module wb_regfile_hilo #(
    parameter int NREG = 32,
    parameter int DW   = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [104:0] wb_to_rf_bus,
    input  logic [4:0]   raddr1,
    output logic [31:0]  rdata1,
    input  logic [4:0]   raddr2,
    output logic [31:0]  rdata2,
    output logic [31:0]  hi_rdata,
    output logic [31:0]  lo_rdata
);

    localparam int AW = 5;

    // -----------------------------------------------------------------------
    // Bus field decode
    // -----------------------------------------------------------------------
    logic [1:0]      mt_flag;
    logic            div_flag;
    logic [2*DW-1:0] div_result;
    logic            rf_we;
    logic [AW-1:0]   rf_waddr;
    logic [DW-1:0]   rf_wdata;

    assign mt_flag    = wb_to_rf_bus[104:103];
    assign div_flag   = wb_to_rf_bus[102];
    assign div_result = wb_to_rf_bus[101:38];
    assign rf_we      = wb_to_rf_bus[37];
    assign rf_waddr   = wb_to_rf_bus[36:32];
    assign rf_wdata   = wb_to_rf_bus[31:0];

    // A write to register 0 is architecturally a no-op.
    logic gpr_wr;
    assign gpr_wr = rf_we && (rf_waddr != '0);

    // -----------------------------------------------------------------------
    // GPR storage. Every register must clear on reset, so the file is built
    // from flops rather than a RAM; register 0 is a constant.
    // -----------------------------------------------------------------------
    logic [DW-1:0] regs_reg [NREG];

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_gpr
            if (gi == 0) begin : g_zero
                assign regs_reg[gi] = '0;
            end else begin : g_store
                always_ff @(posedge clk) begin
                    if (rst) begin
                        regs_reg[gi] <= '0;
                    end else if (gpr_wr && (rf_waddr == AW'(gi))) begin
                        regs_reg[gi] <= rf_wdata;
                    end
                end
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // GPR read ports. Address 0 wins over forwarding so a pending write to
    // register 0 can never leak onto a read port.
    // -----------------------------------------------------------------------
    always_comb begin
        rdata1 = regs_reg[raddr1];
        if (raddr1 == '0) begin
            rdata1 = '0;
        end else if (rf_we && (rf_waddr == raddr1)) begin
            rdata1 = rf_wdata;
        end
    end

    always_comb begin
        rdata2 = regs_reg[raddr2];
        if (raddr2 == '0) begin
            rdata2 = '0;
        end else if (rf_we && (rf_waddr == raddr2)) begin
            rdata2 = rf_wdata;
        end
    end

    // -----------------------------------------------------------------------
    // HI/LO. Divide results take priority over move-to-HI/LO; mt_flag 2'b11
    // is reserved and writes nothing.
    // -----------------------------------------------------------------------
    logic [DW-1:0] hi_reg;
    logic [DW-1:0] lo_reg;
    logic [DW-1:0] hi_next;
    logic [DW-1:0] lo_next;

    always_comb begin
        hi_next = hi_reg;
        lo_next = lo_reg;
        if (div_flag) begin
            hi_next = div_result[2*DW-1:DW];
            lo_next = div_result[DW-1:0];
        end else begin
            case (mt_flag)
                2'b10:   hi_next = rf_wdata;
                2'b01:   lo_next = rf_wdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_reg <= '0;
            lo_reg <= '0;
        end else begin
            hi_reg <= hi_next;
            lo_reg <= lo_next;
        end
    end

`ifdef HILO_BYPASS_EN
    // Same-cycle visibility lets mfhi/mflo follow a HI/LO writer directly.
    assign hi_rdata = hi_next;
    assign lo_rdata = lo_next;
`else
    assign hi_rdata = hi_reg;
    assign lo_rdata = lo_reg;
`endif

endmodule

// File: tb/tb_wb_regfile_hilo.sv
// ---------------------------------------------------------------------------
// tb_wb_regfile_hilo
//
// Self-checking bench for wb_regfile_hilo: directed scenarios followed by a
// randomized run, all compared against a behavioural model of the register
// file and HI/LO pair kept in plain arrays.
// ---------------------------------------------------------------------------
module tb_wb_regfile_hilo;

    logic         clk;
    logic         rst;
    logic [104:0] bus;
    logic [4:0]   raddr1;
    logic [4:0]   raddr2;
    logic [31:0]  rdata1;
    logic [31:0]  rdata2;
    logic [31:0]  hi_rdata;
    logic [31:0]  lo_rdata;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model state
    logic [31:0] m_regs [32];
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    wb_regfile_hilo dut (
        .clk          (clk),
        .rst          (rst),
        .wb_to_rf_bus (bus),
        .raddr1       (raddr1),
        .rdata1       (rdata1),
        .raddr2       (raddr2),
        .rdata2       (rdata2),
        .hi_rdata     (hi_rdata),
        .lo_rdata     (lo_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [104:0] mk_bus(input logic [1:0] mt, input logic dv,
                                            input logic [63:0] dres, input logic we,
                                            input logic [4:0] wa, input logic [31:0] wd);
        return {mt, dv, dres, we, wa, wd};
    endfunction

    // Expected GPR read from the model and the current bus.
    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (bus[37] && bus[36:32] == a) return bus[31:0];
        return m_regs[a];
    endfunction

    // Value HI/LO will hold after this cycle's write (ignoring reset).
    function automatic logic [31:0] new_hi();
        if (bus[102]) return bus[101:70];
        if (bus[104:103] == 2'b10) return bus[31:0];
        return m_hi;
    endfunction

    function automatic logic [31:0] new_lo();
        if (bus[102]) return bus[69:38];
        if (bus[104:103] == 2'b01) return bus[31:0];
        return m_lo;
    endfunction

    function automatic logic [31:0] exp_hi();
`ifdef HILO_BYPASS_EN
        return new_hi();
`else
        return m_hi;
`endif
    endfunction

    function automatic logic [31:0] exp_lo();
`ifdef HILO_BYPASS_EN
        return new_lo();
`else
        return m_lo;
`endif
    endfunction

    // Advance one clock edge and apply the spec's update rules to the model.
    task automatic step();
        logic [31:0] nh;
        logic [31:0] nl;
        @(posedge clk);
        nh = new_hi();
        nl = new_lo();
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            m_hi = 32'd0;
            m_lo = 32'd0;
        end else begin
            if (bus[37] && bus[36:32] != 5'd0) m_regs[bus[36:32]] = bus[31:0];
            m_hi = nh;
            m_lo = nl;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus = mk_bus(2'b10, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5'd5, 32'hFFFF_FFFF);
        step();
        rst = 1'b0;
        bus = '0;
        raddr1 = 5'd5;
        raddr2 = 5'd31;
        #1;
        n_cmp++; if (rdata1 !== 32'd0) begin n_fail++; $display("FAIL reset_rdata1 got=%h want=%h", rdata1, 32'd0); end
        n_cmp++; if (rdata2 !== 32'd0) begin n_fail++; $display("FAIL reset_rdata2 got=%h want=%h", rdata2, 32'd0); end
        n_cmp++; if (hi_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_hi got=%h want=%h", hi_rdata, 32'd0); end
        n_cmp++; if (lo_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_lo got=%h want=%h", lo_rdata, 32'd0); end
        $display("reset: rdata1=%h rdata2=%h hi=%h lo=%h", rdata1, rdata2, hi_rdata, lo_rdata);
    endtask

    task automatic test_reg0();
        bus = mk_bus(2'b00, 1'b0, 64'd0, 1'b1, 5'd0, 32'hDEAD_BEEF);
        raddr1 = 5'd0;
        #1;
        n_cmp++; if (rdata1 !== 32'd0) begin n_fail++; $display("FAIL reg0_same got=%h want=%h", rdata1, 32'd0); end
        step();
        bus = '0;
        #1;
        n_cmp++; if (rdata1 !== 32'd0) begin n_fail++; $display("FAIL reg0_next got=%h want=%h", rdata1, 32'd0); end
        $display("reg0: write DEADBEEF to r0, rdata1=%h", rdata1);
    endtask

    task automatic test_gpr_fwd();
        bus = mk_bus(2'b00, 1'b0, 64'd0, 1'b1, 5'd7, 32'h1234_5678);
        raddr1 = 5'd7;
        raddr2 = 5'd7;
        #1;
        n_cmp++; if (rdata1 !== 32'h1234_5678) begin n_fail++; $display("FAIL fwd_rdata1 got=%h want=%h", rdata1, 32'h1234_5678); end
        n_cmp++; if (rdata2 !== 32'h1234_5678) begin n_fail++; $display("FAIL fwd_rdata2 got=%h want=%h", rdata2, 32'h1234_5678); end
        step();
        bus = '0;
        #1;
        n_cmp++; if (rdata1 !== 32'h1234_5678) begin n_fail++; $display("FAIL stored_rdata1 got=%h want=%h", rdata1, 32'h1234_5678); end
        n_cmp++; if (rdata2 !== 32'h1234_5678) begin n_fail++; $display("FAIL stored_rdata2 got=%h want=%h", rdata2, 32'h1234_5678); end
        $display("gpr_fwd: r7 rdata1=%h rdata2=%h", rdata1, rdata2);
    endtask

    task automatic test_div();
        logic [31:0] prev_hi;
        prev_hi = m_hi;
        bus = mk_bus(2'b10, 1'b1, 64'h0000_0003_0000_0011, 1'b1, 5'd2, 32'h0000_00AA);
        #1;
`ifdef HILO_BYPASS_EN
        n_cmp++; if (hi_rdata !== 32'd3) begin n_fail++; $display("FAIL div_same_hi got=%h want=%h", hi_rdata, 32'd3); end
`else
        n_cmp++; if (hi_rdata !== prev_hi) begin n_fail++; $display("FAIL div_same_hi got=%h want=%h", hi_rdata, prev_hi); end
`endif
        step();
        bus = '0;
        raddr1 = 5'd2;
        #1;
        n_cmp++; if (hi_rdata !== 32'd3) begin n_fail++; $display("FAIL div_hi got=%h want=%h", hi_rdata, 32'd3); end
        n_cmp++; if (lo_rdata !== 32'h11) begin n_fail++; $display("FAIL div_lo got=%h want=%h", lo_rdata, 32'h11); end
        n_cmp++; if (rdata1 !== 32'hAA) begin n_fail++; $display("FAIL div_gpr got=%h want=%h", rdata1, 32'hAA); end
        $display("div: hi=%h lo=%h r2=%h", hi_rdata, lo_rdata, rdata1);
    endtask

    task automatic test_mthilo();
        bus = mk_bus(2'b01, 1'b0, 64'd0, 1'b0, 5'd0, 32'h55);
        step();
        bus = '0;
        #1;
        n_cmp++; if (lo_rdata !== 32'h55) begin n_fail++; $display("FAIL mtlo_lo got=%h want=%h", lo_rdata, 32'h55); end
        n_cmp++; if (hi_rdata !== 32'd3) begin n_fail++; $display("FAIL mtlo_hi got=%h want=%h", hi_rdata, 32'd3); end
        $display("mtlo: hi=%h lo=%h", hi_rdata, lo_rdata);
        bus = mk_bus(2'b11, 1'b0, 64'd0, 1'b0, 5'd0, 32'h99);
        #1;
        n_cmp++; if (hi_rdata !== 32'd3) begin n_fail++; $display("FAIL mt11_same_hi got=%h want=%h", hi_rdata, 32'd3); end
        n_cmp++; if (lo_rdata !== 32'h55) begin n_fail++; $display("FAIL mt11_same_lo got=%h want=%h", lo_rdata, 32'h55); end
        step();
        bus = '0;
        #1;
        n_cmp++; if (hi_rdata !== 32'd3) begin n_fail++; $display("FAIL mt11_hi got=%h want=%h", hi_rdata, 32'd3); end
        n_cmp++; if (lo_rdata !== 32'h55) begin n_fail++; $display("FAIL mt11_lo got=%h want=%h", lo_rdata, 32'h55); end
        $display("mt11: hi=%h lo=%h", hi_rdata, lo_rdata);
        bus = mk_bus(2'b10, 1'b0, 64'd0, 1'b0, 5'd0, 32'hCAFE_0001);
        step();
        bus = '0;
        #1;
        n_cmp++; if (hi_rdata !== 32'hCAFE_0001) begin n_fail++; $display("FAIL mthi_hi got=%h want=%h", hi_rdata, 32'hCAFE_0001); end
        n_cmp++; if (lo_rdata !== 32'h55) begin n_fail++; $display("FAIL mthi_lo got=%h want=%h", lo_rdata, 32'h55); end
        $display("mthi: hi=%h lo=%h", hi_rdata, lo_rdata);
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [3];
        vals[0] = 32'hA0A0_0001;
        vals[1] = 32'hB0B0_0002;
        vals[2] = 32'hC0C0_0003;
        raddr1 = 5'd3;
        raddr2 = 5'd4;
        for (int i = 0; i < 3; i++) begin
            bus = mk_bus(2'b00, 1'b0, 64'd0, 1'b1, 5'd3, vals[i]);
            #1;
            n_cmp++; if (rdata1 !== vals[i]) begin n_fail++; $display("FAIL b2b_fwd%0d got=%h want=%h", i, rdata1, vals[i]); end
            n_cmp++; if (rdata2 !== exp_rd(5'd4)) begin n_fail++; $display("FAIL b2b_other%0d got=%h want=%h", i, rdata2, exp_rd(5'd4)); end
            $display("b2b: write r3=%h rdata1=%h", vals[i], rdata1);
            step();
        end
        bus = '0;
        #1;
        n_cmp++; if (rdata1 !== vals[2]) begin n_fail++; $display("FAIL b2b_final got=%h want=%h", rdata1, vals[2]); end
    endtask

    task automatic test_reset_mid();
        bus = mk_bus(2'b00, 1'b0, 64'd0, 1'b1, 5'd9, 32'h77);
        step();
        bus = mk_bus(2'b10, 1'b0, 64'd0, 1'b0, 5'd0, 32'h1);
        step();
        bus = '0;
        raddr1 = 5'd9;
        #1;
        n_cmp++; if (rdata1 !== 32'h77) begin n_fail++; $display("FAIL rstmid_pre_r9 got=%h want=%h", rdata1, 32'h77); end
        n_cmp++; if (hi_rdata !== 32'h1) begin n_fail++; $display("FAIL rstmid_pre_hi got=%h want=%h", hi_rdata, 32'h1); end
        rst = 1'b1;
        bus = mk_bus(2'b00, 1'b0, 64'd0, 1'b1, 5'd9, 32'h88);
        step();
        rst = 1'b0;
        bus = '0;
        #1;
        n_cmp++; if (rdata1 !== 32'd0) begin n_fail++; $display("FAIL rstmid_r9 got=%h want=%h", rdata1, 32'd0); end
        n_cmp++; if (hi_rdata !== 32'd0) begin n_fail++; $display("FAIL rstmid_hi got=%h want=%h", hi_rdata, 32'd0); end
        n_cmp++; if (lo_rdata !== 32'd0) begin n_fail++; $display("FAIL rstmid_lo got=%h want=%h", lo_rdata, 32'd0); end
        $display("reset_mid: r9=%h hi=%h lo=%h", rdata1, hi_rdata, lo_rdata);
    endtask

    task automatic test_random();
        logic [1:0]  mt;
        logic        dv;
        logic [63:0] dres;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] e1, e2, eh, el;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                bus = '0;
            end else begin
                mt   = 2'($urandom_range(0, 3));
                dv   = ($urandom_range(0, 4) == 0);
                dres = {32'($urandom), 32'($urandom)};
                we   = ($urandom_range(0, 2) != 0);
                wa   = 5'($urandom_range(0, 31));
                wd   = 32'($urandom);
                bus  = mk_bus(mt, dv, dres, we, wa, wd);
            end
            rst = ($urandom_range(0, 59) == 0);
            // Bias reads toward the written address so forwarding is exercised.
            raddr1 = ($urandom_range(0, 2) == 0) ? bus[36:32] : 5'($urandom_range(0, 31));
            raddr2 = ($urandom_range(0, 2) == 0) ? bus[36:32] : 5'($urandom_range(0, 31));
            #1;
            e1 = exp_rd(raddr1);
            e2 = exp_rd(raddr2);
            eh = exp_hi();
            el = exp_lo();
            n_cmp++; if (rdata1 !== e1) begin n_fail++; $display("FAIL rand%0d_rdata1 a=%0d got=%h want=%h", n, raddr1, rdata1, e1); end
            n_cmp++; if (rdata2 !== e2) begin n_fail++; $display("FAIL rand%0d_rdata2 a=%0d got=%h want=%h", n, raddr2, rdata2, e2); end
            n_cmp++; if (hi_rdata !== eh) begin n_fail++; $display("FAIL rand%0d_hi got=%h want=%h", n, hi_rdata, eh); end
            n_cmp++; if (lo_rdata !== el) begin n_fail++; $display("FAIL rand%0d_lo got=%h want=%h", n, lo_rdata, el); end
            $display("rand%0d: rst=%0d bus=%h r1[%0d]=%h r2[%0d]=%h hi=%h lo=%h",
                     n, rst, bus, raddr1, rdata1, raddr2, rdata2, hi_rdata, lo_rdata);
            step();
        end
        rst = 1'b0;
        bus = '0;
    endtask

    initial begin
        rst    = 1'b1;
        bus    = '0;
        raddr1 = 5'd0;
        raddr2 = 5'd0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(posedge clk);
        #1;
        test_reset();
        test_reg0();
        test_gpr_fwd();
        test_div();
        test_mthilo();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
